regfile_writeback: RTL



---
 rtl/regfile_writeback.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Write-back sequencer: buffers execute-stage results in order and drives the
// register file write port at most once per clock, dropping writes to register 0.
module regfile_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_dest,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     EscReg,
  output logic [DATA_W-1:0]     WriteData,
  output logic [(1<<ADDR_W)-1:0] busy_mask,
  output logic [ADDR_W:0]       count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              reg_write_reg;
  logic [ADDR_W-1:0] esc_reg_reg;
  logic [DATA_W-1:0] write_data_reg;

  logic              push;
  logic              pop;
  logic [NREG-1:0]   busy_comb;
  logic [NREG-1:0]   slot_mask [DEPTH];

  // in_ready looks only at occupancy, never at a same-cycle pop.
  assign in_ready = reset_n && (count_reg < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && (in_dest != '0) && !flush;
  assign pop      = (count_reg != '0) && !flush;

  always_ff @(posedge clock) begin
    if (push) begin
      dest_mem[wr_ptr_reg] <= in_dest;
      data_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      reg_write_reg  <= 1'b0;
      esc_reg_reg    <= '0;
      write_data_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      reg_write_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
        reg_write_reg  <= 1'b1;
        esc_reg_reg    <= dest_mem[rd_ptr_reg];
        write_data_reg <= data_mem[rd_ptr_reg];
      end else begin
        reg_write_reg <= 1'b0;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] offset;
    logic             slot_valid;
    assign offset        = PTR_W'(gi) - rd_ptr_reg;
    assign slot_valid    = CNT_W'(offset) < count_reg;
    assign slot_mask[gi] = slot_valid ? (NREG'(1) << dest_mem[gi]) : '0;
  end

  always_comb begin
    busy_comb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_comb = busy_comb | slot_mask[i];
    end
    if (reg_write_reg) begin
      busy_comb = busy_comb | (NREG'(1) << esc_reg_reg);
    end
    busy_comb[0] = 1'b0;
  end

  assign busy_mask = busy_comb;
  assign count     = count_reg;
  assign RegWrite  = reg_write_reg;
  assign EscReg    = esc_reg_reg;
  assign WriteData = write_data_reg;

endmodule
